// File: rtl/draw_grid_overlay.sv
// draw_grid_overlay: N x N board grid plus blinking cursor-cell border drawn
// over the VGA pixel stream, 2-cycle fixed latency on all timing signals.
// Ports: pclk, rst (async, active-low); hcount/hsync/hblnk/vcount/vsync/
//   vblnk/rgb _in -> same _out delayed 2 cycles, rgb_out overlaid;
//   draw_en, cursor_valid, cursor_col, cursor_row latched at vsync rise.
// Optional blink logic: define DRAW_GRID_BLINK_EN.
module draw_grid_overlay #(
  parameter int          GRID_N       = 3,
  parameter int          CELL_W       = 341,
  parameter int          CELL_H       = 256,
  parameter int          LINE_W       = 5,
  parameter int          LINE_H       = 7,
  parameter int          BORDER_W     = 4,
  parameter logic [11:0] GRID_COLOR   = 12'h000,
  parameter logic [11:0] HL_COLOR     = 12'hF00,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        draw_en,
  input  logic        cursor_valid,
  input  logic [2:0]  cursor_col,
  input  logic [2:0]  cursor_row,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int HW = (LINE_W - 1) / 2;
  localparam int HH = (LINE_H - 1) / 2;

  // frame-start detect and frame registers
  logic       vsync_q;
  logic       fs;
  logic       en_q;
  logic       valid_q;
  logic [2:0] col_q;
  logic [2:0] row_q;
  logic       vis;

  assign fs = vsync_in & ~vsync_q;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      col_q   <= 3'd0;
      row_q   <= 3'd0;
    end else begin
      vsync_q <= vsync_in;
      if (fs) begin
        en_q    <= draw_en;
        valid_q <= cursor_valid;
        col_q   <= cursor_col;
        row_q   <= cursor_row;
      end
    end
  end

`ifdef DRAW_GRID_BLINK_EN
  localparam int BCW = $clog2(BLINK_FRAMES + 1);

  logic [BCW-1:0] blink_cnt_q;
  logic           blink_phase_q;
  logic           moved;

  // compared against the previous frame's latched values
  assign moved = (cursor_col != col_q) ||
                 (cursor_row != row_q) ||
                 (cursor_valid && !valid_q);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (fs) begin
      if (moved) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b1;
      end else if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BCW'(1);
      end
    end
  end

  assign vis = blink_phase_q;
`else
  assign vis = 1'b1;
`endif

  // hit detection on the incoming pixel
  int   hx, vx, cx, rx;
  int   hcell, vcell;
  int   lft, rgt, top, bot;
  logic cok;
  logic grid_d;
  logic cur_d;

  always_comb begin
    hx     = {21'd0, hcount_in};
    vx     = {21'd0, vcount_in};
    cx     = {29'd0, col_q};
    rx     = {29'd0, row_q};
    grid_d = 1'b0;
    hcell  = 0;
    vcell  = 0;
    for (int k = 1; k < GRID_N; k++) begin
      if (hx >= k * CELL_W - HW && hx <= k * CELL_W + HW)
        grid_d = 1'b1;
      if (vx >= k * CELL_H - HH && vx <= k * CELL_H + HH)
        grid_d = 1'b1;
      if (hx >= k * CELL_W)
        hcell = hcell + 1;
      if (vx >= k * CELL_H)
        vcell = vcell + 1;
    end
    lft   = cx * CELL_W;
    rgt   = lft + CELL_W - 1;
    top   = rx * CELL_H;
    bot   = top + CELL_H - 1;
    cok   = valid_q && (cx < GRID_N) && (rx < GRID_N);
    // pixels past the last cell edge count as on the far border
    cur_d = cok && vis && (hcell == cx) && (vcell == rx) &&
            ((hx - lft <= BORDER_W) || (hx + BORDER_W >= rgt) ||
             (vx - top <= BORDER_W) || (vx + BORDER_W >= bot));
  end

  // stage 1
  logic [10:0] hcount_q1;
  logic        hsync_q1;
  logic        hblnk_q1;
  logic [10:0] vcount_q1;
  logic        vsync_q1;
  logic        vblnk_q1;
  logic [11:0] rgb_q1;
  logic        en_q1;
  logic        grid_q1;
  logic        cur_q1;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_q1 <= 11'd0;
      hsync_q1  <= 1'b0;
      hblnk_q1  <= 1'b0;
      vcount_q1 <= 11'd0;
      vsync_q1  <= 1'b0;
      vblnk_q1  <= 1'b0;
      rgb_q1    <= 12'd0;
      en_q1     <= 1'b0;
      grid_q1   <= 1'b0;
      cur_q1    <= 1'b0;
    end else begin
      hcount_q1 <= hcount_in;
      hsync_q1  <= hsync_in;
      hblnk_q1  <= hblnk_in;
      vcount_q1 <= vcount_in;
      vsync_q1  <= vsync_in;
      vblnk_q1  <= vblnk_in;
      rgb_q1    <= rgb_in;
      en_q1     <= en_q;
      grid_q1   <= grid_d;
      cur_q1    <= cur_d;
    end
  end

  // stage 2 colour priority
  logic [11:0] rgb_d;

  always_comb begin
    rgb_d = rgb_q1;
    if (hblnk_q1 || vblnk_q1)
      rgb_d = 12'h000;
    else if (!en_q1)
      rgb_d = rgb_q1;
    else if (grid_q1)
      rgb_d = GRID_COLOR;
    else if (cur_q1)
      rgb_d = HL_COLOR;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= 11'd0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'd0;
    end else begin
      hcount_out <= hcount_q1;
      hsync_out  <= hsync_q1;
      hblnk_out  <= hblnk_q1;
      vcount_out <= vcount_q1;
      vsync_out  <= vsync_q1;
      vblnk_out  <= vblnk_q1;
      rgb_out    <= rgb_d;
    end
  end

endmodule
